// File: rtl/amo_rmw_unit.sv
// amo_rmw_unit: executes LR/SC and read-modify-write AMOs as an atomic
// read-then-write sequence on a single memory port. It holds the LR
// reservation and acknowledges each accepted request exactly once.
module amo_rmw_unit #(
  parameter int RSV_GRAN_LOG2 = 3,
  parameter int PLEN          = 56
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            amo_req_i,
  input  logic [3:0]      amo_op_i,
  input  logic [1:0]      amo_size_i,
  input  logic [PLEN-1:0] amo_operand_a_i,
  input  logic [63:0]     amo_operand_b_i,
  output logic            amo_ack_o,
  output logic [63:0]     amo_result_o,
  output logic            mem_req_o,
  input  logic            mem_gnt_i,
  output logic            mem_we_o,
  output logic [PLEN-1:0] mem_addr_o,
  output logic [63:0]     mem_wdata_o,
  output logic [7:0]      mem_be_o,
  input  logic            mem_rvalid_i,
  input  logic [63:0]     mem_rdata_i,
  input  logic            snoop_valid_i,
  input  logic [PLEN-1:0] snoop_addr_i
);

  localparam logic [3:0] AMO_NONE = 4'd0;
  localparam logic [3:0] AMO_LR   = 4'd1;
  localparam logic [3:0] AMO_SC   = 4'd2;
  localparam logic [3:0] AMO_SWAP = 4'd3;
  localparam logic [3:0] AMO_ADD  = 4'd4;
  localparam logic [3:0] AMO_AND  = 4'd5;
  localparam logic [3:0] AMO_OR   = 4'd6;
  localparam logic [3:0] AMO_XOR  = 4'd7;
  localparam logic [3:0] AMO_MAX  = 4'd8;
  localparam logic [3:0] AMO_MAXU = 4'd9;
  localparam logic [3:0] AMO_MIN  = 4'd10;
  localparam logic [3:0] AMO_MINU = 4'd11;

  localparam int TAG_W = PLEN - RSV_GRAN_LOG2;

  typedef enum logic [2:0] {IDLE, READ, READ_WAIT, WRITE, WRITE_WAIT, RESP} state_t;

  state_t            state_reg;
  logic [3:0]        op_reg;
  logic [1:0]        size_reg;
  logic              lane_reg;
  logic [63:0]       data_reg;
  logic              rsv_valid_reg;
  logic [TAG_W-1:0]  rsv_tag_reg;

  logic [TAG_W-1:0]  req_tag;
  logic [TAG_W-1:0]  snoop_tag;
  logic [TAG_W-1:0]  cur_tag;
  logic              snoop_hit;
  logic              sc_ok;
  logic [7:0]        req_be;
  logic [31:0]       rd_lane;
  logic [63:0]       old_val;
  logic [63:0]       b_val;
  logic [63:0]       new_val;
  logic [63:0]       wdata_val;
  logic              unused_bits;

  // The mem address register is the 8-byte-aligned operand address, so its
  // granule bits double as the tag of the access in flight.
  assign req_tag   = amo_operand_a_i[PLEN-1:RSV_GRAN_LOG2];
  assign snoop_tag = snoop_addr_i[PLEN-1:RSV_GRAN_LOG2];
  assign cur_tag   = mem_addr_o[PLEN-1:RSV_GRAN_LOG2];
  assign snoop_hit = snoop_valid_i && rsv_valid_reg && (snoop_tag == rsv_tag_reg);
  // A snoop landing in the same cycle as the SC already kills the reservation.
  assign sc_ok     = rsv_valid_reg && !snoop_hit && (rsv_tag_reg == req_tag);
  assign req_be    = (amo_size_i == 2'b11) ? 8'hFF : (amo_operand_a_i[2] ? 8'hF0 : 8'h0F);

  // Word operands are sign-extended so one 64-bit ALU serves both widths;
  // sign extension preserves both signed and unsigned ordering of words.
  assign rd_lane   = lane_reg ? mem_rdata_i[63:32] : mem_rdata_i[31:0];
  assign old_val   = (size_reg == 2'b11) ? mem_rdata_i : {{32{rd_lane[31]}}, rd_lane};
  assign b_val     = (size_reg == 2'b11) ? data_reg : {{32{data_reg[31]}}, data_reg[31:0]};
  assign wdata_val = (size_reg == 2'b11) ? new_val : {new_val[31:0], new_val[31:0]};
  assign unused_bits = ^{amo_operand_a_i[RSV_GRAN_LOG2-1:0], snoop_addr_i[RSV_GRAN_LOG2-1:0]};

  // ALU: new memory value from the old value and the store operand.
  always_comb begin
    new_val = b_val;
    case (op_reg)
      AMO_ADD:  new_val = old_val + b_val;
      AMO_AND:  new_val = old_val & b_val;
      AMO_OR:   new_val = old_val | b_val;
      AMO_XOR:  new_val = old_val ^ b_val;
      AMO_MAX:  new_val = ($signed(old_val) > $signed(b_val)) ? old_val : b_val;
      AMO_MIN:  new_val = ($signed(old_val) < $signed(b_val)) ? old_val : b_val;
      AMO_MAXU: new_val = (old_val > b_val) ? old_val : b_val;
      AMO_MINU: new_val = (old_val < b_val) ? old_val : b_val;
      default:  new_val = b_val;
    endcase
  end

  // Sequencer, reservation tracking and registered outputs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_reg     <= IDLE;
      op_reg        <= AMO_NONE;
      size_reg      <= 2'b00;
      lane_reg      <= 1'b0;
      data_reg      <= 64'd0;
      rsv_valid_reg <= 1'b0;
      rsv_tag_reg   <= '0;
      amo_ack_o     <= 1'b0;
      amo_result_o  <= 64'd0;
      mem_req_o     <= 1'b0;
      mem_we_o      <= 1'b0;
      mem_addr_o    <= '0;
      mem_wdata_o   <= 64'd0;
      mem_be_o      <= 8'd0;
    end else begin
      amo_ack_o <= 1'b0;
      if (snoop_hit) rsv_valid_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (amo_req_i) begin
            op_reg     <= amo_op_i;
            size_reg   <= amo_size_i;
            lane_reg   <= amo_operand_a_i[2];
            data_reg   <= amo_operand_b_i;
            mem_addr_o <= {amo_operand_a_i[PLEN-1:3], 3'b000};
            mem_be_o   <= req_be;
            if (amo_op_i == AMO_SC) rsv_valid_reg <= 1'b0;
            if (amo_op_i == AMO_NONE || (amo_op_i == AMO_SC && !sc_ok)) begin
              amo_result_o <= (amo_op_i == AMO_SC) ? 64'd1 : 64'd0;
              amo_ack_o    <= 1'b1;
              state_reg    <= RESP;
            end else begin
              mem_req_o <= 1'b1;
              mem_we_o  <= 1'b0;
              state_reg <= READ;
            end
          end
        end
        READ: begin
          if (mem_gnt_i) begin
            mem_req_o <= 1'b0;
            state_reg <= READ_WAIT;
          end
        end
        READ_WAIT: begin
          if (mem_rvalid_i) begin
            if (op_reg == AMO_LR) begin
              amo_result_o  <= old_val;
              rsv_valid_reg <= 1'b1;
              rsv_tag_reg   <= cur_tag;
              amo_ack_o     <= 1'b1;
              state_reg     <= RESP;
            end else begin
              amo_result_o <= (op_reg == AMO_SC) ? 64'd0 : old_val;
              mem_wdata_o  <= wdata_val;
              mem_req_o    <= 1'b1;
              mem_we_o     <= 1'b1;
              state_reg    <= WRITE;
            end
          end
        end
        WRITE: begin
          if (mem_gnt_i) begin
            mem_req_o <= 1'b0;
            mem_we_o  <= 1'b0;
            state_reg <= WRITE_WAIT;
          end
        end
        WRITE_WAIT: begin
          if (mem_rvalid_i) begin
            if (rsv_valid_reg && rsv_tag_reg == cur_tag) rsv_valid_reg <= 1'b0;
            amo_ack_o <= 1'b1;
            state_reg <= RESP;
          end
        end
        RESP: begin
          state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  // Only word and doubleword accesses are meaningful for AMOs.
  size_legal: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (state_reg == IDLE && amo_req_i && amo_op_i != AMO_NONE) |-> amo_size_i[1]);

endmodule
